multi_phase_traffic_controller: RTL
===================================

Name: multi_phase_traffic_controller

Overview:
- Generalised intersection controller for NUM_DIR approaches, each with one car sensor and one 3-bit light.
- Shared pedestrian request with an all-red walk phase.
- Integrated down-counter timer; no external timer module.
- Round-robin service of requesting approaches, with bounded green extension. Sits between the sensor-sync block and the lamp drivers.

Parameters:
NUM_DIR, 4, number of approaches (2..8)
TW, 5, internal timer width; every duration below must be 1..2^TW
GREEN_T, 8, base green duration in cycles
EXT_T, 4, green extension duration in cycles
MAX_EXT, 2, maximum extensions per green phase
YELLOW_T, 3, yellow duration in cycles
ALLRED_T, 2, all-red clearance duration in cycles
PED_T, 12, pedestrian walk duration in cycles

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
car  input  NUM_DIR  car present per approach, level, synchronous to clk
ped_req  input  1  pedestrian request, pulse or level
light  output  3*NUM_DIR  per-approach light, approach i at [3i+2:3i]; 001 red, 010 yellow, 100 green
ped_walk  output  1  walk signal
phase  output  clog2(NUM_DIR)  approach currently or last served
state  output  3  FSM state: IDLE=0, GREEN=1, YELLOW=2, ALL_RED=3, PED=4
timer_out  output  TW  remaining cycles minus one in the current timed state

Behaviour:
- Reset state:
  - state=IDLE, all lights 001, ped_walk=0, phase=NUM_DIR-1 (so the first search starts at approach 0).
  - Pedestrian latch cleared, extension count 0, timer_out 0.
  - Reset asserted mid-phase returns to this state immediately and asynchronously.
- Timer:
  - On entry to a timed state, timer_out is loaded with duration-1. It decrements once per cycle.
  - The state exits on the cycle timer_out==0, so a state lasts exactly its duration.
- Pedestrian latch:
  - Set on any cycle ped_req=1 while state!=PED; cleared on entry to PED.
  - ped_req during PED is ignored.
- Outputs are registered and change on the same edge as state.
- Selection function:
  - Search approaches phase+1, phase+2, ... mod NUM_DIR and pick the first with car=1.
  - The current phase is checked last, so a single requester is re-served.
- Transitions:
  - IDLE (all red, untimed):
    - Pedestrian latch set -> PED.
    - Else any car -> GREEN with phase=selected approach.
    - Else stay.
    - Pedestrian has priority over cars.
  - GREEN (light[phase]=100, others 001), duration GREEN_T. At timer_out==0:
    - If car[phase]=1 and no other car and latch clear and ext_cnt<MAX_EXT -> reload EXT_T, ext_cnt++.
    - Else -> YELLOW.
    - ext_cnt clears on GREEN entry.
  - YELLOW (light[phase]=010), duration YELLOW_T -> ALL_RED.
  - ALL_RED (all 001, ped_walk=0), duration ALLRED_T. Then:
    - Latch set -> PED.
    - Else any car -> GREEN(selected).
    - Else -> IDLE.
  - PED (all 001, ped_walk=1), duration PED_T -> ALL_RED. phase is unchanged.
- Safety invariants:
  - Never more than one approach non-red.
  - ped_walk=1 only with all lights red.
  - Every GREEN is followed by YELLOW then ALL_RED.
- Car deassertion during GREEN does not shorten the base green.
- Simultaneous ped_req and car at IDLE -> PED first.

Test Plan:
- Reset, car=0000, ped_req=0 for 20 cycles -> state=0, light=001001001001, ped_walk=0 throughout; async rst mid-GREEN forces all-red within the same cycle.
- car=0001 held constant from idle:
  - GREEN phase 0 lasts 8+4+4=16 cycles (two extensions, then capped).
  - Then YELLOW 3 cycles, ALL_RED 2, then GREEN phase 0 again.
- car=1011 held constant:
  - Greens served in order 0,1,3,0, each exactly 8 cycles (no extensions).
  - Each green is separated by 3 yellow and 2 all-red cycles.
- ped_req 1-cycle pulse during GREEN phase 1 with car=0010:
  - No extension granted.
  - Then YELLOW 3, ALL_RED 2, PED 12 with ped_walk=1 and all red, ALL_RED 2, then GREEN phase 1.
- ped_req and car=0100 asserted together from IDLE:
  - PED first for 12 cycles, ALL_RED 2, then GREEN phase 2.
  - ped_req held during PED does not cause a second PED.
- Invariant checker every cycle across random car/ped stimulus for 10k cycles:
  - At most one non-red light.
  - No 100→001 transition without an intervening 010.
  - ped_walk implies all red.

Source files
------------

// File: rtl/multi_phase_traffic_controller.sv
// Multi-approach intersection controller.
// Approaches with a car waiting are served round-robin. A lone requester can
// have its green extended a bounded number of times. A latched pedestrian
// request inserts an all-red walk phase. Every output is registered and
// changes on the same clock edge as the state.
module multi_phase_traffic_controller #(
  parameter int NUM_DIR  = 4,
  parameter int TW       = 5,
  parameter int GREEN_T  = 8,
  parameter int EXT_T    = 4,
  parameter int MAX_EXT  = 2,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int PED_T    = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_DIR-1:0]           car,
  input  logic                         ped_req,
  output logic [3*NUM_DIR-1:0]         light,
  output logic                         ped_walk,
  output logic [$clog2(NUM_DIR)-1:0]   phase,
  output logic [2:0]                   state,
  output logic [TW-1:0]                timer_out
);

  localparam int PW = $clog2(NUM_DIR);
  localparam int EW = $clog2(MAX_EXT + 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GREEN   = 3'd1,
    YELLOW  = 3'd2,
    ALL_RED = 3'd3,
    PED     = 3'd4
  } state_t;

  state_t             st, st_nx;
  logic [PW-1:0]      phase_nx, sel, idx;
  logic [TW-1:0]      timer_nx;
  logic [EW-1:0]      ext_cnt, ext_nx;
  logic               ped_latch, latch_nx, ped_pend;
  logic               found, other_car, dispatch;
  logic [NUM_DIR-1:0] phase_mask;
  logic [3*NUM_DIR-1:0] light_nx;

  assign state    = st;
  assign ped_pend = ped_latch | ped_req;

  // Round-robin pick: scan phase+1 .. phase+NUM_DIR, so the current phase comes last
  always_comb begin
    sel   = phase;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_DIR; k++) begin
      idx = PW'((32'(phase) + k) % NUM_DIR);
      if (!found && car[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // Detect cars waiting on any approach other than the one currently served
  always_comb begin
    phase_mask = '0;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      if (PW'(i) == phase) phase_mask[i] = 1'b1;
    end
    other_car = |(car & ~phase_mask);
  end

  // Next-state, timer and extension logic
  always_comb begin
    st_nx    = st;
    phase_nx = phase;
    timer_nx = timer_out;
    ext_nx   = ext_cnt;
    dispatch = 1'b0;
    case (st)
      IDLE: dispatch = 1'b1;
      GREEN: begin
        if (timer_out == '0) begin
          if (car[phase] && !other_car && !ped_pend && (ext_cnt < EW'(MAX_EXT))) begin
            timer_nx = TW'(EXT_T - 1);
            ext_nx   = ext_cnt + EW'(1);
          end else begin
            st_nx    = YELLOW;
            timer_nx = TW'(YELLOW_T - 1);
          end
        end else begin
          timer_nx = timer_out - TW'(1);
        end
      end
      YELLOW: begin
        if (timer_out == '0) begin
          st_nx    = ALL_RED;
          timer_nx = TW'(ALLRED_T - 1);
        end else begin
          timer_nx = timer_out - TW'(1);
        end
      end
      ALL_RED: begin
        if (timer_out == '0) dispatch = 1'b1;
        else                 timer_nx = timer_out - TW'(1);
      end
      PED: begin
        if (timer_out == '0) begin
          st_nx    = ALL_RED;
          timer_nx = TW'(ALLRED_T - 1);
        end else begin
          timer_nx = timer_out - TW'(1);
        end
      end
      default: begin
        st_nx    = IDLE;
        timer_nx = '0;
      end
    endcase

    // IDLE and the end of ALL_RED share one decision: pedestrian first, then cars
    if (dispatch) begin
      if (ped_pend) begin
        st_nx    = PED;
        timer_nx = TW'(PED_T - 1);
      end else if (|car) begin
        st_nx    = GREEN;
        phase_nx = sel;
        timer_nx = TW'(GREEN_T - 1);
        ext_nx   = '0;
      end else begin
        st_nx    = IDLE;
        timer_nx = '0;
      end
    end
  end

  // Pedestrian latch: cleared on PED entry, set by any request outside PED
  always_comb begin
    latch_nx = ped_latch;
    if (st_nx == PED && st != PED) latch_nx = 1'b0;
    else if (st != PED && ped_req) latch_nx = 1'b1;
  end

  // Lamp pattern for the state being entered
  always_comb begin
    light_nx = {NUM_DIR{3'b001}};
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      if (PW'(i) == phase_nx) begin
        if (st_nx == GREEN)       light_nx[3*i +: 3] = 3'b100;
        else if (st_nx == YELLOW) light_nx[3*i +: 3] = 3'b010;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      phase     <= PW'(NUM_DIR - 1);
      timer_out <= '0;
      ext_cnt   <= '0;
      ped_latch <= 1'b0;
      light     <= {NUM_DIR{3'b001}};
      ped_walk  <= 1'b0;
    end else begin
      st        <= st_nx;
      phase     <= phase_nx;
      timer_out <= timer_nx;
      ext_cnt   <= ext_nx;
      ped_latch <= latch_nx;
      light     <= light_nx;
      ped_walk  <= (st_nx == PED);
    end
  end

endmodule
